id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage core, with integrated load-use hazard detection.
- Captures decoded operands, register addresses and control bits from ID on every clock edge.
- Its registered ID_EX_RegisterRs, ID_EX_RegisterRt and control outputs drive the forwarding unit and the EX stage.
- Generates the PC / IF-ID hold signals and inserts bubbles on load-use stalls and branch flushes.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/hazard_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word layout, ALUOp encodings and the bubble constant.
package pipe_pkg;

    localparam int unsigned CTRL_W        = 9;

    localparam int unsigned CTRL_REGWRITE = 8;
    localparam int unsigned CTRL_MEMTOREG = 7;
    localparam int unsigned CTRL_MEMREAD  = 6;
    localparam int unsigned CTRL_MEMWRITE = 5;
    localparam int unsigned CTRL_ALUSRC   = 4;
    localparam int unsigned CTRL_ALUOP_HI = 3;
    localparam int unsigned CTRL_ALUOP_LO = 2;
    localparam int unsigned CTRL_REGDST   = 1;
    localparam int unsigned CTRL_BRANCH   = 0;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: stalls PC and IF/ID for one cycle when ID reads a pending load target.
module hazard_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              flush,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write
);

    logic hazard;

    always_comb begin
        hazard      = mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
        // A flushed ID instruction is discarded, so there is nothing to wait for.
        stall       = hazard && !flush;
        pc_write    = !stall;
        if_id_write = !stall;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Optional STALL_CNT_EN adds a saturating stall counter on StallCount_o.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] IF_ID_RegisterRs,
    input  logic [REG_AW-1:0] IF_ID_RegisterRt,
    input  logic [REG_AW-1:0] IF_ID_RegisterRd,
    input  logic [DATA_W-1:0] RsData_i,
    input  logic [DATA_W-1:0] RtData_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [CTRL_W-1:0] Ctrl_i,
    input  logic              Flush_i,
    output logic [REG_AW-1:0] ID_EX_RegisterRs,
    output logic [REG_AW-1:0] ID_EX_RegisterRt,
    output logic [REG_AW-1:0] ID_EX_RegisterRd,
    output logic [DATA_W-1:0] ID_EX_RsData,
    output logic [DATA_W-1:0] ID_EX_RtData,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [CTRL_W-1:0] ID_EX_Ctrl,
    output logic              PCWrite_o,
    output logic              IF_ID_Write_o,
    output logic              Stall_o
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  StallCount_o
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("id_ex_stage: CNT_W must be at least 1");
    end

    logic [1:0] rst_sync;
    logic       rst_n;
    logic       stall;

    // Assert asynchronously, release two edges later in the clk_i domain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .mem_read    (ctrl_mem_read(ID_EX_Ctrl)),
        .ex_rt       (ID_EX_RegisterRt),
        .id_rs       (IF_ID_RegisterRs),
        .id_rt       (IF_ID_RegisterRt),
        .flush       (Flush_i),
        .stall       (stall),
        .pc_write    (PCWrite_o),
        .if_id_write (IF_ID_Write_o)
    );

    assign Stall_o = stall;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_RegisterRs <= '0;
            ID_EX_RegisterRt <= '0;
            ID_EX_RegisterRd <= '0;
            ID_EX_RsData     <= '0;
            ID_EX_RtData     <= '0;
            ID_EX_Imm        <= '0;
            ID_EX_Ctrl       <= CTRL_BUBBLE;
        end else begin
            ID_EX_RegisterRs <= IF_ID_RegisterRs;
            ID_EX_RegisterRt <= IF_ID_RegisterRt;
            ID_EX_RegisterRd <= IF_ID_RegisterRd;
            ID_EX_RsData     <= RsData_i;
            ID_EX_RtData     <= RtData_i;
            ID_EX_Imm        <= Imm_i;
            ID_EX_Ctrl       <= (stall || Flush_i) ? CTRL_BUBBLE : Ctrl_i;
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            StallCount_o <= '0;
        end else if (stall && (StallCount_o != '1)) begin
            StallCount_o <= StallCount_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expectations, a negedge monitor checks them.
module tb_id_ex_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 2;

    localparam logic [8:0] C_NOP = 9'h000;
    localparam logic [8:0] C_LW  = 9'h1D0;
    localparam logic [8:0] C_ALU = 9'h10A;
    localparam logic [8:0] C_SW  = 9'h030;
    localparam logic [8:0] C_BEQ = 9'h005;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b1;
    logic [REG_AW-1:0] IF_ID_RegisterRs = '0;
    logic [REG_AW-1:0] IF_ID_RegisterRt = '0;
    logic [REG_AW-1:0] IF_ID_RegisterRd = '0;
    logic [DATA_W-1:0] RsData_i = '0;
    logic [DATA_W-1:0] RtData_i = '0;
    logic [DATA_W-1:0] Imm_i = '0;
    logic [8:0]        Ctrl_i = '0;
    logic              Flush_i = 1'b0;
    logic [REG_AW-1:0] ID_EX_RegisterRs;
    logic [REG_AW-1:0] ID_EX_RegisterRt;
    logic [REG_AW-1:0] ID_EX_RegisterRd;
    logic [DATA_W-1:0] ID_EX_RsData;
    logic [DATA_W-1:0] ID_EX_RtData;
    logic [DATA_W-1:0] ID_EX_Imm;
    logic [8:0]        ID_EX_Ctrl;
    logic              PCWrite_o;
    logic              IF_ID_Write_o;
    logic              Stall_o;
`ifdef STALL_CNT_EN
    logic [CNT_W-1:0]  StallCount_o;
`endif

    id_ex_stage #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .IF_ID_RegisterRd (IF_ID_RegisterRd),
        .RsData_i         (RsData_i),
        .RtData_i         (RtData_i),
        .Imm_i            (Imm_i),
        .Ctrl_i           (Ctrl_i),
        .Flush_i          (Flush_i),
        .ID_EX_RegisterRs (ID_EX_RegisterRs),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .ID_EX_RegisterRd (ID_EX_RegisterRd),
        .ID_EX_RsData     (ID_EX_RsData),
        .ID_EX_RtData     (ID_EX_RtData),
        .ID_EX_Imm        (ID_EX_Imm),
        .ID_EX_Ctrl       (ID_EX_Ctrl),
        .PCWrite_o        (PCWrite_o),
        .IF_ID_Write_o    (IF_ID_Write_o),
        .Stall_o          (Stall_o)
`ifdef STALL_CNT_EN
        ,
        .StallCount_o     (StallCount_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [8:0]  ctrl;
        logic        flush;
        logic        exp_stall;
        logic [8:0]  exp_ctrl;
    } vec_t;

    typedef struct {
        logic        stall;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [8:0]  ctrl;
        logic [31:0] cnt;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    task automatic add_vec(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                           input logic [8:0] ctrl, input logic flush,
                           input logic exp_stall, input logic [8:0] exp_ctrl);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd;
        v.rsd = rsd; v.rtd = rtd; v.imm = imm;
        v.ctrl = ctrl; v.flush = flush;
        v.exp_stall = exp_stall; v.exp_ctrl = exp_ctrl;
        tbl.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        IF_ID_RegisterRs = v.rs;
        IF_ID_RegisterRt = v.rt;
        IF_ID_RegisterRd = v.rd;
        RsData_i         = v.rsd;
        RtData_i         = v.rtd;
        Imm_i            = v.imm;
        Ctrl_i           = v.ctrl;
        Flush_i          = v.flush;
    endtask

    task automatic check_bubble(input string tag);
        chk({tag, "_rs"},    32'(ID_EX_RegisterRs), 32'd0);
        chk({tag, "_rt"},    32'(ID_EX_RegisterRt), 32'd0);
        chk({tag, "_rd"},    32'(ID_EX_RegisterRd), 32'd0);
        chk({tag, "_rsd"},   ID_EX_RsData, 32'd0);
        chk({tag, "_rtd"},   ID_EX_RtData, 32'd0);
        chk({tag, "_imm"},   ID_EX_Imm, 32'd0);
        chk({tag, "_ctrl"},  32'(ID_EX_Ctrl), 32'd0);
        chk({tag, "_stall"}, 32'(Stall_o), 32'd0);
        chk({tag, "_pcw"},   32'(PCWrite_o), 32'd1);
        chk({tag, "_ifidw"}, 32'(IF_ID_Write_o), 32'd1);
`ifdef STALL_CNT_EN
        chk({tag, "_cnt"},   32'(StallCount_o), 32'd0);
`endif
    endtask

    // Monitor: every cycle with a pending expectation is checked mid-cycle.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk_i);
            if (sb.size() != 0) begin
                m = sb.pop_front();
                chk("stall",    32'(Stall_o), 32'(m.stall));
                chk("pc_write", 32'(PCWrite_o), 32'(!m.stall));
                chk("ifid_wr",  32'(IF_ID_Write_o), 32'(!m.stall));
                chk("ex_rs",    32'(ID_EX_RegisterRs), 32'(m.rs));
                chk("ex_rt",    32'(ID_EX_RegisterRt), 32'(m.rt));
                chk("ex_rd",    32'(ID_EX_RegisterRd), 32'(m.rd));
                chk("ex_rsd",   ID_EX_RsData, m.rsd);
                chk("ex_rtd",   ID_EX_RtData, m.rtd);
                chk("ex_imm",   ID_EX_Imm, m.imm);
                chk("ex_ctrl",  32'(ID_EX_Ctrl), 32'(m.ctrl));
`ifdef STALL_CNT_EN
                chk("stall_cnt", 32'(StallCount_o), m.cnt);
`endif
            end
        end
    end

    initial begin
        exp_t        e;
        vec_t        idle;
        int unsigned cnt_model;

        //       rs     rt     rd     rsd           rtd           imm           ctrl   fl    stall exp_ctrl
        add_vec(5'd3,  5'd4,  5'd7,  32'hDEADBEEF, 32'h12345678, 32'h00000000, C_ALU, 1'b0, 1'b0, C_ALU); // normal flow
        add_vec(5'd1,  5'd5,  5'd0,  32'h00000100, 32'h00000000, 32'h00000008, C_LW,  1'b0, 1'b0, C_LW);  // lw $5
        add_vec(5'd5,  5'd6,  5'd9,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, C_ALU, 1'b0, 1'b1, C_NOP); // use $5 -> stall
        add_vec(5'd5,  5'd6,  5'd9,  32'hA5A5A5A6, 32'h5A5A5A5B, 32'h00000000, C_ALU, 1'b0, 1'b0, C_ALU); // replay after bubble
        add_vec(5'd2,  5'd0,  5'd0,  32'h00000200, 32'h00000000, 32'h0000000C, C_LW,  1'b0, 1'b0, C_LW);  // lw $0
        add_vec(5'd0,  5'd0,  5'd3,  32'h00000000, 32'h00000000, 32'h00000000, C_ALU, 1'b0, 1'b0, C_ALU); // reads $0: no stall
        add_vec(5'd4,  5'd8,  5'd0,  32'h00000400, 32'h00000000, 32'h00000010, C_LW,  1'b0, 1'b0, C_LW);  // lw $8
        add_vec(5'd1,  5'd8,  5'd0,  32'h11111111, 32'h88888888, 32'hFFFFFFFC, C_BEQ, 1'b1, 1'b0, C_NOP); // hazard + flush
        add_vec(5'd8,  5'd2,  5'd0,  32'h80808080, 32'h20202020, 32'h00000004, C_SW,  1'b0, 1'b0, C_SW);  // after flushed bubble
        add_vec(5'd3,  5'd10, 5'd0,  32'h00000300, 32'h00000000, 32'h00000020, C_LW,  1'b0, 1'b0, C_LW);  // lw $10
        add_vec(5'd11, 5'd10, 5'd12, 32'hCAFEF00D, 32'h0BADF00D, 32'h00000000, C_ALU, 1'b0, 1'b1, C_NOP); // rt match -> stall
        add_vec(5'd11, 5'd10, 5'd12, 32'hCAFEF00E, 32'h0BADF00E, 32'h00000000, C_ALU, 1'b0, 1'b0, C_ALU);
        add_vec(5'd0,  5'd12, 5'd0,  32'h00000000, 32'h00000000, 32'h00000030, C_LW,  1'b0, 1'b0, C_LW);  // lw $12
        add_vec(5'd12, 5'd13, 5'd0,  32'h00000C00, 32'h00000000, 32'h00000034, C_LW,  1'b0, 1'b1, C_NOP); // dependent lw $13
        add_vec(5'd12, 5'd13, 5'd0,  32'h00000C01, 32'h00000000, 32'h00000034, C_LW,  1'b0, 1'b0, C_LW);
        add_vec(5'd13, 5'd1,  5'd14, 32'h13131313, 32'h01010101, 32'h00000000, C_ALU, 1'b0, 1'b1, C_NOP); // use $13 -> stall
        add_vec(5'd13, 5'd1,  5'd14, 32'h13131314, 32'h01010102, 32'h00000000, C_ALU, 1'b0, 1'b0, C_ALU);
        add_vec(5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'h00000000, C_NOP, 1'b0, 1'b0, C_NOP);
        add_vec(5'd0,  5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'h00000000, C_NOP, 1'b0, 1'b0, C_NOP);

        idle = '{rs: 5'd0, rt: 5'd0, rd: 5'd0, rsd: 32'd0, rtd: 32'd0, imm: 32'd0,
                 ctrl: C_NOP, flush: 1'b0, exp_stall: 1'b0, exp_ctrl: C_NOP};

        // Reset asserted away from any clock edge: outputs must be a bubble at once.
        #2 rst_n_i = 1'b0;
        #1 check_bubble("reset");
        #20 rst_n_i = 1'b1;
        repeat (4) @(posedge clk_i);

        cnt_model = 0;
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk_i); #1;
            drive(tbl[k]);
            e.stall = tbl[k].exp_stall;
            if (k == 0) begin
                e.rs = '0; e.rt = '0; e.rd = '0;
                e.rsd = '0; e.rtd = '0; e.imm = '0; e.ctrl = '0;
            end else begin
                e.rs = tbl[k-1].rs; e.rt = tbl[k-1].rt; e.rd = tbl[k-1].rd;
                e.rsd = tbl[k-1].rsd; e.rtd = tbl[k-1].rtd; e.imm = tbl[k-1].imm;
                e.ctrl = tbl[k-1].exp_ctrl;
            end
            e.cnt = 32'(cnt_model);
            sb.push_back(e);
            if (tbl[k].exp_stall && cnt_model != ((1 << CNT_W) - 1)) cnt_model++;
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk_i);
        if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);

        // Reset while a load-use stall is being signalled.
        @(posedge clk_i); #1;
        drive('{rs: 5'd0, rt: 5'd5, rd: 5'd0, rsd: 32'h1, rtd: 32'h2, imm: 32'h3,
                ctrl: C_LW, flush: 1'b0, exp_stall: 1'b0, exp_ctrl: C_LW});
        @(posedge clk_i); #1;
        drive('{rs: 5'd5, rt: 5'd6, rd: 5'd7, rsd: 32'h4, rtd: 32'h5, imm: 32'h6,
                ctrl: C_ALU, flush: 1'b0, exp_stall: 1'b1, exp_ctrl: C_NOP});
        #2 chk("pre_reset_stall", 32'(Stall_o), 32'd1);
        rst_n_i = 1'b0;
        #1 check_bubble("midstall_reset");
        drive(idle);
        #10 rst_n_i = 1'b1;
        repeat (3) @(posedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
